// File: rtl/soc_reset_sequencer.sv
// SoC reset sequencer: waits for a stable clock lock, pulses the DRAM
// controller reset, waits for DRAM calibration, then releases peripherals
// and finally the core. Lock loss or a software request restarts the chain.
module soc_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 64,
  parameter int CALIB_TIMEOUT      = 2**20,
  parameter bit USE_DDR            = 1'b1
) (
  input  logic       soc_clk,
  input  logic       rst_n,
  input  logic       clk_locked_i,
  input  logic       ddr_calib_done_i,
  input  logic       sw_rst_req_i,
  input  logic       test_mode_i,
  input  logic [1:0] boot_mode_i,
  output logic       dram_rst_o,
  output logic       periph_rst_no,
  output logic       core_rst_no,
  output logic [1:0] boot_mode_o,
  output logic       ready_o,
  output logic       calib_err_o,
  output logic [2:0] state_o
);

  localparam int MAX_A = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                         LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int MAX_P = (MAX_A > CALIB_TIMEOUT) ? MAX_A : CALIB_TIMEOUT;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK   = 3'd0,
    S_LOCK_STABLE = 3'd1,
    S_DRAM_RST    = 3'd2,
    S_WAIT_CALIB  = 3'd3,
    S_PERIPH_REL  = 3'd4,
    S_RUN         = 3'd5,
    S_ERROR       = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_restart;
  logic             w_cnt_clr;
  logic             r_dram_rst;
  logic             r_periph_rst_n;
  logic             r_core_rst_n;
  logic             r_ready;
  logic             r_calib_err;
  logic [1:0]       r_boot_mode;

  // Next-state selection: lock loss beats software request beats progression.
  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    if (r_state == S_WAIT_LOCK) begin
      if (clk_locked_i) w_next = S_LOCK_STABLE;
    end else if (r_state > S_ERROR) begin
      // Unused encoding 7 falls back to the start of the chain.
      w_next = S_WAIT_LOCK;
    end else if (!clk_locked_i) begin
      w_next = S_WAIT_LOCK;
    end else if (sw_rst_req_i) begin
      // Also restarts the hold count when already in DRAM_RST.
      w_next    = S_DRAM_RST;
      w_restart = 1'b1;
    end else begin
      case (r_state)
        S_LOCK_STABLE: if (r_cnt == LOCK_LAST) w_next = S_DRAM_RST;
        S_DRAM_RST:    if (r_cnt == HOLD_LAST)
                         w_next = USE_DDR ? S_WAIT_CALIB : S_PERIPH_REL;
        S_WAIT_CALIB: begin
          if (ddr_calib_done_i)         w_next = S_PERIPH_REL;
          else if (r_cnt == CALIB_LAST) w_next = S_ERROR;
        end
        S_PERIPH_REL:  if (r_cnt == HOLD_LAST) w_next = S_RUN;
        default:       w_next = r_state;
      endcase
    end
  end

  assign w_cnt_clr = w_restart | (w_next != r_state);

  // State register.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT_LOCK;
    else        r_state <= w_next;
  end

  // Shared dwell counter, cleared whenever a transition is taken.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (w_cnt_clr) r_cnt <= '0;
    else                r_cnt <= r_cnt + CNT_W'(1);
  end

  // Registered output decode of the next state, aligned with state_o.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dram_rst     <= 1'b1;
      r_periph_rst_n <= 1'b0;
      r_core_rst_n   <= 1'b0;
      r_ready        <= 1'b0;
      r_calib_err    <= 1'b0;
    end else begin
      r_dram_rst     <= (w_next == S_WAIT_LOCK) || (w_next == S_LOCK_STABLE) ||
                        (w_next == S_DRAM_RST);
      r_periph_rst_n <= (w_next == S_PERIPH_REL) || (w_next == S_RUN);
      r_core_rst_n   <= (w_next == S_RUN);
      r_ready        <= (w_next == S_RUN);
      r_calib_err    <= (w_next == S_ERROR);
    end
  end

  // Boot mode is sampled once, as the core comes out of reset.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n)
      r_boot_mode <= 2'b00;
    else if ((r_state == S_PERIPH_REL) && (w_next == S_RUN))
      r_boot_mode <= boot_mode_i;
  end

  // DFT bypass hands the reset outputs straight to the pin reset.
  assign dram_rst_o    = test_mode_i ? ~rst_n : r_dram_rst;
  assign periph_rst_no = test_mode_i ?  rst_n : r_periph_rst_n;
  assign core_rst_no   = test_mode_i ?  rst_n : r_core_rst_n;
  assign boot_mode_o   = r_boot_mode;
  assign ready_o       = r_ready;
  assign calib_err_o   = r_calib_err;
  assign state_o       = r_state;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer with short timing parameters.
module tb_soc_reset_sequencer;

  logic       soc_clk;
  logic       rst_n;
  logic       clk_locked_i;
  logic       ddr_calib_done_i;
  logic       sw_rst_req_i;
  logic       test_mode_i;
  logic [1:0] boot_mode_i;
  logic       dram_rst_o;
  logic       periph_rst_no;
  logic       core_rst_no;
  logic [1:0] boot_mode_o;
  logic       ready_o;
  logic       calib_err_o;
  logic [2:0] state_o;

  int n_vec;
  int n_err;

  soc_reset_sequencer #(
    .LOCK_STABLE_CYCLES(4),
    .RST_HOLD_CYCLES   (2),
    .CALIB_TIMEOUT     (16),
    .USE_DDR           (1'b1)
  ) dut (
    .soc_clk         (soc_clk),
    .rst_n           (rst_n),
    .clk_locked_i    (clk_locked_i),
    .ddr_calib_done_i(ddr_calib_done_i),
    .sw_rst_req_i    (sw_rst_req_i),
    .test_mode_i     (test_mode_i),
    .boot_mode_i     (boot_mode_i),
    .dram_rst_o      (dram_rst_o),
    .periph_rst_no   (periph_rst_no),
    .core_rst_no     (core_rst_no),
    .boot_mode_o     (boot_mode_o),
    .ready_o         (ready_o),
    .calib_err_o     (calib_err_o),
    .state_o         (state_o)
  );

  initial begin
    soc_clk = 1'b0;
    forever #5 soc_clk = ~soc_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int exp);
    chk(tag, 32'(state_o), exp[31:0]);
  endtask

  // Checks dram_rst_o, periph_rst_no, core_rst_no, ready_o, calib_err_o.
  task automatic chk_outs(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, dram_rst_o, periph_rst_no, core_rst_no, ready_o, calib_err_o},
        {27'd0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge soc_clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    clk_locked_i = 1'b0;
    ddr_calib_done_i = 1'b0;
    sw_rst_req_i = 1'b0;
    test_mode_i = 1'b0;
    boot_mode_i = 2'b00;

    // Power-on reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk_st("por_state", 0);
    chk_outs("por_outs", 5'b10000);
    chk("por_boot", 32'(boot_mode_o), 32'd0);
    step(2);
    rst_n = 1'b1;

    // Idle without lock; software request ignored in WAIT_LOCK.
    step(1);
    chk_st("idle_no_lock", 0);
    sw_rst_req_i = 1'b1;
    step(1);
    sw_rst_req_i = 1'b0;
    chk_st("sw_in_wait_lock", 0);

    // Normal boot.
    clk_locked_i = 1'b1;
    boot_mode_i = 2'b10;
    step(1);
    chk_st("boot_ls_entry", 1);
    chk_outs("boot_ls_outs", 5'b10000);
    step(3);
    chk_st("boot_ls_hold", 1);
    step(1);
    chk_st("boot_dram_entry", 2);
    chk_outs("boot_dram_outs", 5'b10000);
    step(1);
    chk_st("boot_dram_hold", 2);
    step(1);
    chk_st("boot_calib_entry", 3);
    chk_outs("boot_calib_outs", 5'b00000);
    step(2);
    chk_st("boot_calib_wait", 3);
    ddr_calib_done_i = 1'b1;
    step(1);
    ddr_calib_done_i = 1'b0;
    chk_st("boot_periph_entry", 4);
    chk_outs("boot_periph_outs", 5'b01000);
    step(1);
    chk_st("boot_periph_hold", 4);
    chk_outs("boot_core_held", 5'b01000);
    step(1);
    chk_st("boot_run", 5);
    chk_outs("boot_run_outs", 5'b01110);
    chk("boot_mode_latched", 32'(boot_mode_o), 32'd2);
    boot_mode_i = 2'b01;
    step(3);
    chk_st("run_stays", 5);
    chk("boot_mode_held", 32'(boot_mode_o), 32'd2);

    // Lock loss in RUN.
    clk_locked_i = 1'b0;
    step(1);
    chk_st("run_lock_loss", 0);
    chk_outs("run_lock_loss_outs", 5'b10000);
    chk("boot_mode_kept", 32'(boot_mode_o), 32'd2);

    // Lock glitch at LOCK_STABLE count 2, then full re-qualification.
    clk_locked_i = 1'b1;
    step(3);
    chk_st("glitch_pre", 1);
    clk_locked_i = 1'b0;
    step(1);
    chk_st("glitch_drop", 0);
    clk_locked_i = 1'b1;
    step(1);
    chk_st("relock_entry", 1);
    step(3);
    chk_st("relock_full_count", 1);
    step(1);
    chk_st("relock_dram", 2);

    // Calibration timeout.
    step(2);
    chk_st("to_calib_entry", 3);
    step(15);
    chk_st("to_before", 3);
    step(1);
    chk_st("to_error", 6);
    chk_outs("to_error_outs", 5'b00001);
    step(4);
    chk_st("error_sticky", 6);

    // Software request leaves ERROR; repeat in DRAM_RST restarts the hold.
    sw_rst_req_i = 1'b1;
    step(1);
    sw_rst_req_i = 1'b0;
    chk_st("sw_from_error", 2);
    chk_outs("sw_from_error_outs", 5'b10000);
    step(1);
    chk_st("sw_dram_cnt1", 2);
    sw_rst_req_i = 1'b1;
    step(1);
    sw_rst_req_i = 1'b0;
    chk_st("sw_dram_restart", 2);
    step(1);
    chk_st("sw_dram_rehold", 2);
    step(1);
    chk_st("sw_dram_done", 3);

    // Software request together with lock drop goes to WAIT_LOCK.
    step(16);
    chk_st("error_again", 6);
    sw_rst_req_i = 1'b1;
    clk_locked_i = 1'b0;
    step(1);
    sw_rst_req_i = 1'b0;
    chk_st("sw_and_lock_drop", 0);
    chk_outs("sw_and_lock_drop_outs", 5'b10000);

    // Asynchronous reset in the middle of WAIT_CALIB.
    clk_locked_i = 1'b1;
    step(7);
    chk_st("mid_calib", 3);
    step(2);
    #2 rst_n = 1'b0;
    #1;
    chk_st("async_rst_state", 0);
    chk_outs("async_rst_outs", 5'b10000);
    chk("async_rst_boot", 32'(boot_mode_o), 32'd0);

    // DFT bypass: reset outputs follow rst_n directly.
    test_mode_i = 1'b1;
    #1;
    chk_outs("tm_rst_low", 5'b10000);
    rst_n = 1'b1;
    #1;
    chk_outs("tm_rst_high", 5'b01100);
    rst_n = 1'b0;
    #1;
    chk_outs("tm_rst_low2", 5'b10000);
    rst_n = 1'b1;
    test_mode_i = 1'b0;
    #1;
    chk_outs("tm_off", 5'b10000);

    // Calibration done on the timeout cycle wins over the timeout.
    step(1);
    chk_st("prio_ls", 1);
    step(6);
    chk_st("prio_calib_entry", 3);
    step(15);
    ddr_calib_done_i = 1'b1;
    step(1);
    ddr_calib_done_i = 1'b0;
    chk_st("prio_calib_wins", 4);
    chk_outs("prio_calib_outs", 5'b01000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/soc_reset_sequencer.md
SOC_RESET_SEQUENCER -- requirements
Module: soc_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, cycles clk_locked_i must stay high before DRAM reset is applied.
REQ-002 SHALL have parameter RST_HOLD_CYCLES, default 64, length of the DRAM reset pulse and of the peripheral-before-core release gap.
REQ-003 SHALL have parameter CALIB_TIMEOUT, default 2**20, maximum cycles spent waiting for DRAM calibration.
REQ-004 SHALL have parameter USE_DDR, default 1; when 0, calibration wait is skipped.
REQ-005 soc_clk  in  1  SoC clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low; clock soc_clk.
REQ-007 clk_locked_i  in  1  clock-wizard lock, synchronous to soc_clk.
REQ-008 ddr_calib_done_i  in  1  DRAM controller calibration complete level.
REQ-009 sw_rst_req_i  in  1  single-cycle software/VIO reset request.
REQ-010 test_mode_i  in  1  DFT bypass.
REQ-011 boot_mode_i  in  2  live boot-mode selection.
REQ-012 dram_rst_o  out  1  active-high DRAM controller reset.
REQ-013 periph_rst_no  out  1  active-low peripheral/USB reset.
REQ-014 core_rst_no  out  1  active-low core/SoC reset.
REQ-015 boot_mode_o  out  2  boot mode latched at core release.
REQ-016 ready_o  out  1  high only in RUN.
REQ-017 calib_err_o  out  1  high only in ERROR.
REQ-018 state_o  out  3  current state encoding.

Function
REQ-019 States/encodings SHALL be WAIT_LOCK=0, LOCK_STABLE=1, DRAM_RST=2, WAIT_CALIB=3, PERIPH_REL=4, RUN=5, ERROR=6; encoding 7 SHALL recover to WAIT_LOCK.
REQ-020 One shared cycle counter, width $clog2 of the largest parameter plus 1, SHALL be cleared on every state change and increment otherwise.
REQ-021 WAIT_LOCK: clk_locked_i=1 -> LOCK_STABLE.
REQ-022 LOCK_STABLE: counter==LOCK_STABLE_CYCLES-1 with lock high -> DRAM_RST.
REQ-023 DRAM_RST: counter==RST_HOLD_CYCLES-1 -> WAIT_CALIB if USE_DDR=1, else PERIPH_REL.
REQ-024 WAIT_CALIB: ddr_calib_done_i=1 -> PERIPH_REL; else counter==CALIB_TIMEOUT-1 -> ERROR; calib_done takes priority on the same cycle.
REQ-025 PERIPH_REL: counter==RST_HOLD_CYCLES-1 -> RUN; boot_mode_i SHALL be captured into boot_mode_o on this transition and held until the next entry to RUN.
REQ-026 Priority in every state except WAIT_LOCK: clk_locked_i=0 -> WAIT_LOCK, overriding all else; then sw_rst_req_i=1 -> DRAM_RST; then normal progression.
REQ-027 sw_rst_req_i in WAIT_LOCK SHALL be ignored; in DRAM_RST it SHALL restart the hold count.
REQ-028 ERROR SHALL be left only via lock loss or sw_rst_req_i.
REQ-029 Outputs SHALL be registered decodes of next state, changing on the same edge as state_o: dram_rst_o=1 in states 0-2; periph_rst_no=1 in 4,5; core_rst_no=1 in 5; ready_o=1 in 5; calib_err_o=1 in 6.
REQ-030 Net latency lock-rise to core release (USE_DDR=0): 1+LOCK_STABLE_CYCLES+2*RST_HOLD_CYCLES cycles.
REQ-031 test_mode_i=1 SHALL combinationally force core_rst_no=periph_rst_no=rst_n and dram_rst_o=~rst_n; the FSM keeps running underneath.

Reset
REQ-032 rst_n=0 SHALL immediately force state WAIT_LOCK, counter 0, dram_rst_o=1, periph_rst_no=0, core_rst_no=0, ready_o=0, calib_err_o=0, boot_mode_o=2'b00, state_o=0, including mid-sequence.

Verification (LOCK_STABLE_CYCLES=4, RST_HOLD_CYCLES=2, CALIB_TIMEOUT=16)
REQ-033 Normal boot: lock high at cycle 0, calib_done high 3 cycles after WAIT_CALIB entry, boot_mode_i=2'b10 -> states 1,2,3,4,5 in order; periph_rst_no rises 2 cycles before core_rst_no; boot_mode_o=2'b10, unchanged after boot_mode_i->2'b01.
REQ-034 Calibration timeout: calib_done held 0 -> ERROR exactly 16 cycles after WAIT_CALIB entry; calib_err_o=1, all resets asserted except dram_rst_o=0, state_o=6.
REQ-035 Lock glitch: lock drops at LOCK_STABLE count 2 -> WAIT_LOCK next edge; re-lock requires full 4 stable cycles.
REQ-036 Lock loss in RUN -> next edge core_rst_no=0, periph_rst_no=0, dram_rst_o=1, ready_o=0, state_o=0.
REQ-037 sw_rst_req_i in ERROR -> DRAM_RST, calib_err_o=0; sw_rst_req_i with lock drop on the same cycle -> WAIT_LOCK.
REQ-038 rst_n asserted mid WAIT_CALIB -> all outputs at REQ-032 values without a clock edge; test_mode_i=1 -> core_rst_no tracks rst_n directly.
